// File: rtl/uart_pkg.sv
// uart_pkg: receiver state encoding, framing constants and tick divisor helper.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_SAMPLE = 7;
  localparam int unsigned DATA_BITS  = 8;

  // Clocks per oversample tick, truncated, never below 1.
  function automatic int unsigned tick_div(input int unsigned clk_freq, input int unsigned baud);
    int unsigned d;
    d = clk_freq / (baud * OVERSAMPLE);
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead FIFO with extra-MSB pointers; shared with the TX side.
// A push while full is accepted only when a pop frees the slot in the same cycle.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  // pointer update; wraps naturally modulo 2*DEPTH
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // storage write; contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled serial receiver, 8N1 LSB first, into a show-ahead FIFO.
// Build option UART_RX_PARITY_EN: 8E1 framing with a PARITY state and parity_err pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_full,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       parity_err
);
  localparam int unsigned DIV = tick_div(CLK_FREQ, BAUD);
  localparam int unsigned TW  = (DIV > 1) ? $clog2(DIV) : 1;

  rx_state_e      state, state_nxt;
  logic [1:0]     sync;
  logic           rxd_s;
  logic [TW-1:0]  tick_cnt;
  logic           tick;
  logic [3:0]     s_cnt, s_cnt_nxt;
  logic [2:0]     b_cnt, b_cnt_nxt;
  logic [7:0]     shreg, shreg_nxt;
  logic           push;
  logic           ferr_nxt;
  logic           ovr_nxt;
  logic           par_ok;
  logic [7:0]     fifo_head;
  logic           fifo_full;
  logic           fifo_empty;
`ifdef UART_RX_PARITY_EN
  logic           par_bit, par_nxt;
  logic           perr_nxt;
`endif

  assign rxd_s = sync[1];
  assign tick  = (state != RX_IDLE) && (tick_cnt == TW'(DIV - 1));

  // two-flop synchronizer, reset high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (!reset) sync <= 2'b11;
    else        sync <= {sync[0], rxd};
  end

  // oversample tick divider, held cleared while idle so the start edge aligns it
  always_ff @(posedge clk) begin
    if (!reset || state == RX_IDLE) tick_cnt <= '0;
    else if (tick)                  tick_cnt <= '0;
    else                            tick_cnt <= tick_cnt + TW'(1);
  end

  // FSM and datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= RX_IDLE;
      s_cnt <= '0;
      b_cnt <= '0;
      shreg <= '0;
`ifdef UART_RX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      s_cnt <= s_cnt_nxt;
      b_cnt <= b_cnt_nxt;
      shreg <= shreg_nxt;
`ifdef UART_RX_PARITY_EN
      par_bit <= par_nxt;
`endif
    end
  end

  // next-state, bit sampling and stop-bit evaluation
  always_comb begin
    state_nxt = state;
    s_cnt_nxt = s_cnt;
    b_cnt_nxt = b_cnt;
    shreg_nxt = shreg;
    push      = 1'b0;
    ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_nxt   = par_bit;
    perr_nxt  = 1'b0;
    par_ok    = (par_bit == ^shreg);
`else
    par_ok    = 1'b1;
`endif
    case (state)
      RX_IDLE: begin
        s_cnt_nxt = '0;
        b_cnt_nxt = '0;
        if (!rxd_s) state_nxt = RX_START;
      end
      RX_START: if (tick) begin
        if (s_cnt == 4'(MID_SAMPLE)) begin
          s_cnt_nxt = '0;
          b_cnt_nxt = '0;
          state_nxt = rxd_s ? RX_IDLE : RX_DATA;
        end else begin
          s_cnt_nxt = s_cnt + 4'd1;
        end
      end
      RX_DATA: if (tick) begin
        s_cnt_nxt = s_cnt + 4'd1;
        if (s_cnt == 4'(OVERSAMPLE - 1)) begin
          shreg_nxt = {rxd_s, shreg[7:1]};
          b_cnt_nxt = b_cnt + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (b_cnt == 3'(DATA_BITS - 1)) state_nxt = RX_PARITY;
`else
          if (b_cnt == 3'(DATA_BITS - 1)) state_nxt = RX_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: if (tick) begin
        s_cnt_nxt = s_cnt + 4'd1;
        if (s_cnt == 4'(OVERSAMPLE - 1)) begin
          par_nxt   = rxd_s;
          state_nxt = RX_STOP;
        end
      end
`endif
      RX_STOP: if (tick) begin
        s_cnt_nxt = s_cnt + 4'd1;
        if (s_cnt == 4'(OVERSAMPLE - 1)) begin
          push      = rxd_s && par_ok;
          ferr_nxt  = !rxd_s;
`ifdef UART_RX_PARITY_EN
          perr_nxt  = !par_ok;
`endif
          state_nxt = RX_IDLE;
        end
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  assign ovr_nxt = push && fifo_full && !(rx_ready && !fifo_empty);

  // registered one-cycle error pulses, aligned with the push becoming visible
  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= ferr_nxt;
      overrun_err <= ovr_nxt;
    end
  end

`ifdef UART_RX_PARITY_EN
  // parity error pulse register
  always_ff @(posedge clk) begin
    if (!reset) parity_err <= 1'b0;
    else        parity_err <= perr_nxt;
  end
`else
  assign parity_err = 1'b0;
`endif

  uart_rx_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (shreg),
    .pop   (rx_ready),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rx_valid = !fifo_empty;
  assign rx_full  = fifo_full;
  assign rx_data  = fifo_empty ? 8'h00 : fifo_head;

endmodule
